// File: rtl/sumador_arbiter.sv
// Round-robin arbiter/sequencer sharing one 16-bit sumador adder among NREQ requesters.
// Latency: accept at t -> registered response valid at t+2; peak one op per 3 cycles.
// Backpressure: response held stable in RESP until rsp_ready; no new accepts while busy.

module sumador (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] C
);
    assign C = A + B;
endmodule

module sumador_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_carry,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [15:0]          op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic [15:0]    op_a;
    logic [15:0]    op_b;
    logic [15:0]    sel_a;
    logic [15:0]    sel_b;
    logic [15:0]    sum_c;
    int             idx;

    sumador u_sumador (
        .A (op_a),
        .B (op_b),
        .C (sum_c)
    );

    // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        idx       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
                sel_a     = req_a[16*idx +: 16];
                sel_b     = req_b[16*idx +: 16];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any && !rst)
            req_ready[grant_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            cur_id     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        cur_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_c;
                    rsp_carry <= (sum_c < op_a);
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sumador_arbiter.sv
// Directed bench for sumador_arbiter: reset, single op, carry, round-robin, backpressure, abort, wrap.
module tb_sumador_arbiter;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [15:0]          rsp_sum;
    logic                 rsp_carry;
    logic                 rsp_ready;
    logic                 busy;
    logic [15:0]          op_count;

    int total = 0;
    int bad   = 0;

    sumador_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_sum !== 16'h0 || rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin
            bad++; $display("FAIL reset_rsp got sum=%h id=%0d c=%b exp 0/0/0", rsp_sum, rsp_id, rsp_carry); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (op_count !== 16'h0) begin bad++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        req_valid = 4'b0001; req_a[15:0] = 16'h0003; req_b[15:0] = 16'h0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_accept got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_exec got busy=%b rsp_valid=%b exp 1/0", busy, rsp_valid); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0004 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin
            bad++; $display("FAIL single_rsp got v=%b sum=%h c=%b id=%0d exp 1/0004/0/0", rsp_valid, rsp_sum, rsp_carry, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_done got v=%b cnt=%0d busy=%b exp 0/1/0", rsp_valid, op_count, busy); end
    endtask

    task automatic test_carry();
        req_valid = 4'b0100; req_a[47:32] = 16'hFFFF; req_b[47:32] = 16'h0001;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL carry_accept got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0000 || rsp_carry !== 1'b1 || rsp_id !== 2'd2) begin
            bad++; $display("FAIL carry_rsp got v=%b sum=%h c=%b id=%0d exp 1/0000/1/2", rsp_valid, rsp_sum, rsp_carry, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (op_count !== 16'd2) begin bad++; $display("FAIL carry_count got=%0d exp=2", op_count); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_sum [4];
        logic        exp_c   [4];
        int nacc = 0, nrsp = 0, last_acc = -3, id;
        exp_sum[0] = 16'h1100; exp_c[0] = 1'b0;
        exp_sum[1] = 16'h2201; exp_c[1] = 1'b0;
        exp_sum[2] = 16'h3302; exp_c[2] = 1'b0;
        exp_sum[3] = 16'h0403; exp_c[3] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_a = {16'hF003, 16'h3002, 16'h2001, 16'h1000};
        req_b = {16'h1400, 16'h0300, 16'h0200, 16'h0100};
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cyc == 13) req_valid = '0;
            #1;
            if (req_ready != 4'b0000) begin
                id = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
                total++; if (req_ready !== (4'b0001 << (nacc % 4))) begin
                    bad++; $display("FAIL rr_order accept%0d got=%b exp_id=%0d", nacc, req_ready, nacc % 4); end
                total++; if (cyc - last_acc != 3) begin
                    bad++; $display("FAIL rr_spacing accept%0d got gap=%0d exp=3", nacc, cyc - last_acc); end
                last_acc = cyc;
                nacc++;
            end
            if (rsp_valid === 1'b1) begin
                total++; if (rsp_sum !== exp_sum[rsp_id] || rsp_carry !== exp_c[rsp_id] || rsp_id !== 2'((nrsp) % 4)) begin
                    bad++; $display("FAIL rr_rsp%0d got id=%0d sum=%h c=%b exp id=%0d", nrsp, rsp_id, rsp_sum, rsp_carry, nrsp % 4); end
                nrsp++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        total++; if (nacc != 5 || nrsp != 5) begin bad++; $display("FAIL rr_counts got acc=%0d rsp=%0d exp 5/5", nacc, nrsp); end
        total++; if (op_count !== 16'd5) begin bad++; $display("FAIL rr_op_count got=%0d exp=5", op_count); end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0010; req_a[31:16] = 16'h1234; req_b[31:16] = 16'h1111;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_accept got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h2345 || rsp_id !== 2'd1 || rsp_carry !== 1'b0
                         || busy !== 1'b1 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold%0d got v=%b sum=%h id=%0d c=%b busy=%b rdy=%b", i, rsp_valid, rsp_sum, rsp_id, rsp_carry, busy, req_ready); end
            @(negedge clk);
        end
        req_valid = '0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || op_count !== 16'd6 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_release got v=%b cnt=%0d busy=%b exp 0/6/0", rsp_valid, op_count, busy); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100; req_a[47:32] = 16'h0005; req_b[47:32] = 16'h0005;
        @(negedge clk);
        req_valid = 4'b1111; rst = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL abort_state got v=%b cnt=%0d busy=%b rdy=%b", rsp_valid, op_count, busy, req_ready); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_no_rsp got v=%b exp=0", rsp_valid); end
        rst = 1'b0;
        req_a = {16'h0004, 16'h0003, 16'h0002, 16'h0010};
        req_b = {16'h0001, 16'h0001, 16'h0001, 16'h0020};
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL abort_first_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        total++; if (rsp_sum !== 16'h0030 || rsp_id !== 2'd0) begin
            bad++; $display("FAIL abort_rsp got sum=%h id=%0d exp 0030/0", rsp_sum, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (op_count !== 16'd1) begin bad++; $display("FAIL abort_count got=%0d exp=1", op_count); end
    endtask

    task automatic test_wrap();
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        #1;
        total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=FFFF", op_count); end
        req_valid = 4'b1000; req_a[63:48] = 16'h0007; req_b[63:48] = 16'h0008;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        total++; if (rsp_sum !== 16'h000F || rsp_id !== 2'd3) begin
            bad++; $display("FAIL wrap_rsp got sum=%h id=%0d exp 000F/3", rsp_sum, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
